audio_dac_tx: RTL and testbench
===============================

// Module: audio_dac_tx
// PURPOSE
//  I2S transmitter toward the codec DAC; the playback counterpart of the ADC receive path.
//  Buffers stereo samples from the processor/DSP side (valid/ready sink) in a small FIFO.
//  Serialises them onto DACDAT against codec-mastered BCLK/DACLRCK, MSB first, standard I2S timing.
//  Sits beside the audio-in core in the system top; BCLK is shared with the ADC path.
// PARAMETERS
//  DATA_WIDTH   16  bits per channel sample
//  FIFO_DEPTH   8   stereo pairs buffered; power of two, >=2
// PORTS
//  clk_clk                  in   1              system clock; must be >=4x BCLK frequency
//  reset_reset_n            in   1              async active-low reset
//  sample_left              in   DATA_WIDTH     left sample, two's complement
//  sample_right             in   DATA_WIDTH     right sample, two's complement
//  sample_valid             in   1              pair offered
//  sample_ready             out  1              pair accepted when valid&&ready
//  fifo_level               out  $clog2(D)+1    stereo pairs currently stored
//  underflow                out  1              1-cycle pulse: frame started with FIFO empty
//  audio_interface_BCLK     in   1              codec bit clock (async)
//  audio_interface_DACLRCK  in   1              codec word clock (async); 0=left, 1=right
//  audio_interface_DACDAT   out  1              serial data to codec
// BEHAVIOUR
//  Reset: sample_ready=0 during reset, 1 in the first cycle after release; fifo_level=0;
//   underflow=0; DACDAT=0; FIFO emptied; shifter idle.
//  Sync: BCLK and DACLRCK each pass through a 2-flop synchroniser, then one edge-detect register.
//   bclk_fall = prev&~cur; lrck_edge = prev^cur; lrck_fall = prev&~cur.
//  FIFO: sample_ready = ~full. Push on valid&&ready. Pop only on lrck_fall (left frame start).
//   Push and pop in the same cycle: level unchanged. A push is never accepted while full, even if a
//   pop occurs that cycle. Pointers wrap modulo FIFO_DEPTH.
//  Frame load on lrck_fall: non-empty -> pop pair, L->shift reg, R->hold reg.
//   Empty -> load zeros to both, underflow=1 for that cycle only.
//   On lrck rising edge: hold reg (R) -> shift reg.
//  FSM states:
//   IDLE: out of reset; DACDAT=0; transmits nothing until the first lrck_fall; go ARM.
//   ARM: lrck edge seen; a bclk_fall in the same cycle as lrck_edge is ignored.
//    The next bclk_fall drives MSB; go SHIFT.
//   SHIFT: each bclk_fall drives the next lower bit. After the LSB has been driven, go PAD.
//   PAD: the next bclk_fall drives 0. DACDAT holds 0 until the next lrck_edge -> ARM.
//  Any lrck_edge in SHIFT/PAD (short frame) reloads the shifter and returns to ARM; remaining bits
//   are dropped.
//  DACDAT is registered and changes only in a cycle with bclk_fall, so the codec samples it
//   stably on the BCLK rise. Latency: 3-4 clk_clk from the physical BCLK fall.
//  Reset mid-frame: FIFO flushed, DACDAT=0 immediately (async), state returns to IDLE.
//   No partial frame is resumed.
// STRUCTURE
//  Shared package audio_pkg: AUDIO_DATA_WIDTH=16; typedef stereo_sample_t {left, right}.
//   The ADC receiver shares the same package.
//  Sub-module audio_sample_fifo: single-clock FIFO of stereo_sample_t.
//   Ports: push/pop, full/empty/level; async active-low reset.
//  Top holds the synchronisers, edge detect, FSM and shift/hold registers.
// TESTING
//  Bench codec model: BCLK = clk_clk/8; LRCK toggles on a BCLK fall every 32 BCLK.
//   Model samples DACDAT on BCLK rise.
//  Basic: push L=16'hA5C3, R=16'h0F0F.
//   -> Left slot bits 2..17 after LRCK fall read 16'hA5C3, right slot reads 16'h0F0F.
//   -> Remaining slots 0; no underflow.
//  Underflow: no pushes after reset -> underflow pulses once per LRCK fall, DACDAT constant 0.
//  Backpressure: push 8 pairs before the first frame -> fifo_level=8, sample_ready=0.
//   -> A 9th pair held off. Ready returns 1 cycle after the next lrck_fall pop; level=7.
//  Simultaneous: level=3, push in the lrck_fall cycle -> level stays 3.
//   -> Popped pair is the oldest; FIFO order preserved.
//  Reset mid-frame: assert reset_reset_n=0 at bit 6 of a left word.
//   -> DACDAT=0 at once, level=0, ready=0.
//   -> After release, output stays 0 until the first full left frame after the next LRCK fall.
//  Short frame: LRCK toggles after 10 BCLK.
//   -> Shifter reloads; the next word starts with its MSB at the correct slot.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types for the codec ADC/DAC paths.
// Sample width, stereo pair bundle and DAC serialiser states.
package audio_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ARM,
        TX_SHIFT,
        TX_PAD
    } dac_tx_state_t;

endpackage

// File: rtl/audio_dac_tx_if.sv
// Stereo sample stream from the DSP side into the DAC path.
// One pair moves on each cycle with valid and ready both high.
interface audio_dac_tx_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] sample_left;
    logic [DATA_WIDTH-1:0] sample_right;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_left,
        output sample_right,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left,
        input  sample_right,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/audio_sample_fifo.sv
// Single-clock FIFO of stereo pairs feeding the DAC serialiser.
// Pushes are refused while full, even when a pop lands in the same cycle.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter type      T     = stereo_sample_t,
    parameter int       DEPTH = 8,
    localparam int      AW    = $clog2(DEPTH),
    localparam int      LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  T              wr_data,
    input  logic          pop,
    output T              rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Sample storage; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level <= level + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter toward the codec DAC, slaved to codec BCLK/DACLRCK.
// Buffers stereo pairs and shifts them out MSB first with a one-bit delay.
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int  DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int  FIFO_DEPTH = 8,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1,
    localparam int CW         = $clog2(DATA_WIDTH)
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    audio_dac_tx_if.slave  sample_if,
    output logic [LW-1:0]  fifo_level,
    output logic           underflow,
    input  logic           audio_interface_BCLK,
    input  logic           audio_interface_DACLRCK,
    output logic           audio_interface_DACDAT
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } pair_t;

    logic [1:0]            bclk_sync;
    logic [1:0]            lrck_sync;
    logic                  bclk_prev;
    logic                  lrck_prev;
    logic                  bclk_fall;
    logic                  lrck_edge;
    logic                  lrck_fall;
    logic                  ready_en;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    pair_t                 wr_pair;
    pair_t                 rd_pair;
    dac_tx_state_t         state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [CW-1:0]         bit_cnt;
    logic                  dacdat_q;
    logic                  underflow_q;

    assign bclk_fall = bclk_prev & ~bclk_sync[1];
    assign lrck_edge = lrck_prev ^ lrck_sync[1];
    assign lrck_fall = lrck_prev & ~lrck_sync[1];

    assign sample_if.sample_ready = ready_en & ~fifo_full;
    assign push                   = sample_if.sample_valid & sample_if.sample_ready;
    assign wr_pair.left           = sample_if.sample_left;
    assign wr_pair.right          = sample_if.sample_right;

    assign underflow              = underflow_q;
    assign audio_interface_DACDAT = dacdat_q;

    // Bring the codec clocks into clk_clk and keep one stage for edge detect.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], audio_interface_BCLK};
            lrck_sync <= {lrck_sync[0], audio_interface_DACLRCK};
            bclk_prev <= bclk_sync[1];
            lrck_prev <= lrck_sync[1];
        end
    end

    // Hold ready low through reset and open it on the first clock after.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    audio_sample_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push),
        .wr_data (wr_pair),
        .pop     (lrck_fall),
        .rd_data (rd_pair),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Frame loading and bit serialiser; word-clock edges outrank bit clocks.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= TX_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            bit_cnt     <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            underflow_q <= lrck_fall & fifo_empty;
            if (lrck_fall) begin
                shift_q <= fifo_empty ? '0 : rd_pair.left;
                hold_q  <= fifo_empty ? '0 : rd_pair.right;
                state   <= TX_ARM;
            end else if (lrck_edge && state != TX_IDLE) begin
                shift_q <= hold_q;
                state   <= TX_ARM;
            end else if (bclk_fall) begin
                unique case (state)
                    TX_IDLE: begin
                        dacdat_q <= 1'b0;
                    end
                    TX_ARM: begin
                        dacdat_q <= shift_q[DATA_WIDTH-1];
                        shift_q  <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt  <= CW'(1);
                        state    <= TX_SHIFT;
                    end
                    TX_SHIFT: begin
                        dacdat_q <= shift_q[DATA_WIDTH-1];
                        shift_q  <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            state <= TX_PAD;
                        end
                    end
                    TX_PAD: begin
                        dacdat_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx with a BCLK=clk/8 codec model sampling on BCLK rise.
// Directed vector table plus hand sequences for backpressure, reset, short frames.
module tb_audio_dac_tx;
    import audio_pkg::*;

    localparam int DW = AUDIO_DATA_WIDTH;
    localparam int LW = 4;

    typedef struct {
        logic        lr;
        logic [63:0] cap;
    } frame_t;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        int            exp_level;
    } vec_t;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          bclk  = 1'b1;
    logic          lrck  = 1'b1;
    logic [LW-1:0] fifo_level;
    logic          underflow;
    logic          dacdat;

    int     n_cmp    = 0;
    int     n_bad    = 0;
    int     uf_cnt   = 0;
    int     ones_cnt = 0;
    int     half_len = 32;
    int     rd       = 0;
    frame_t frames[$];

    audio_dac_tx_if sif ();

    audio_dac_tx dut (
        .clk_clk                 (clk),
        .reset_reset_n           (rst_n),
        .sample_if               (sif),
        .fifo_level              (fifo_level),
        .underflow               (underflow),
        .audio_interface_BCLK    (bclk),
        .audio_interface_DACLRCK (lrck),
        .audio_interface_DACDAT  (dacdat)
    );

    always #5 clk = ~clk;

    // Codec: BCLK edges on clk negedges, LRCK toggles on a BCLK fall.
    initial begin : codec
        int          fcnt;
        int          slot;
        logic [63:0] cap;
        fcnt = 0;
        slot = 0;
        cap  = '0;
        forever begin
            repeat (4) @(negedge clk);
            bclk = 1'b0;
            fcnt++;
            if (fcnt >= half_len) begin
                frames.push_back('{lr: lrck, cap: cap});
                lrck = ~lrck;
                fcnt = 0;
                slot = 0;
                cap  = '0;
            end
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            slot++;
            if (slot < 64) cap[slot] = dacdat;
        end
    end

    always @(negedge clk) begin
        if (underflow) uf_cnt++;
        if (dacdat) ones_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int t;
        t = 0;
        @(negedge clk);
        sif.sample_left  = l;
        sif.sample_right = r;
        sif.sample_valid = 1'b1;
        while (!sif.sample_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!sif.sample_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got ready=0, want 1");
        end
        @(negedge clk);
        sif.sample_valid = 1'b0;
    endtask

    task automatic get_rec(output frame_t f);
        int t;
        t = 0;
        while (frames.size() <= rd && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (frames.size() > rd) begin
            f = frames[rd];
            rd++;
        end else begin
            f.lr  = 1'bx;
            f.cap = '1;
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got no frame, want one");
        end
    endtask

    function automatic logic [DW-1:0] slot_word(input logic [63:0] c, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[DW-1-i] = c[2+i];
        return w;
    endfunction

    function automatic logic [63:0] rest_bits(input logic [63:0] c);
        logic [63:0] m;
        m = c;
        for (int i = 2; i < 2 + DW; i++) m[i] = 1'b0;
        return m;
    endfunction

    task automatic check_pair(input string tag, input logic [DW-1:0] l,
                              input logic [DW-1:0] r);
        frame_t f;
        get_rec(f);
        check({tag, "_l_slot"}, 64'(f.lr), 64'd0);
        check({tag, "_l_word"}, 64'(slot_word(f.cap, DW)), 64'(l));
        check({tag, "_l_rest"}, rest_bits(f.cap), 64'd0);
        get_rec(f);
        check({tag, "_r_slot"}, 64'(f.lr), 64'd1);
        check({tag, "_r_word"}, 64'(slot_word(f.cap, DW)), 64'(r));
        check({tag, "_r_rest"}, rest_bits(f.cap), 64'd0);
    endtask

    initial begin
        vec_t          tbl[3];
        logic [DW-1:0] bp[9];
        logic [DW-1:0] sp[4];
        logic [DW-1:0] sh[3];
        frame_t        f;
        int            uf0;
        int            ones0;

        tbl[0] = '{l: 16'hA5C3, r: 16'h0F0F, exp_level: 1};
        tbl[1] = '{l: 16'h8001, r: 16'h7FFE, exp_level: 2};
        tbl[2] = '{l: 16'hFFFF, r: 16'h0000, exp_level: 3};
        for (int i = 0; i < 9; i++) bp[i] = 16'h1000 + 16'(i) * 16'h1111;
        for (int i = 0; i < 4; i++) sp[i] = 16'h3C50 + 16'(i) * 16'h0203;
        sh[0] = 16'hB6D9;
        sh[1] = 16'h6D9B;
        sh[2] = 16'hD9B6;

        sif.sample_left  = '0;
        sif.sample_right = '0;
        sif.sample_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(sif.sample_ready), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_dacdat", 64'(dacdat), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(sif.sample_ready), 64'd1);

        // Underflow: empty FIFO, one pulse per LRCK fall, silent line
        @(negedge lrck);
        repeat (10) @(negedge clk);
        uf0   = uf_cnt;
        ones0 = ones_cnt;
        repeat (3) begin
            @(negedge lrck);
            repeat (10) @(negedge clk);
        end
        check("uf_count", 64'(uf_cnt - uf0), 64'd3);
        check("uf_dacdat_zero", 64'(ones_cnt - ones0), 64'd0);

        // Table vectors: push, level, then frame contents in order
        for (int i = 0; i < 3; i++) begin
            push(tbl[i].l, tbl[i].r);
            check("tbl_level", 64'(fifo_level), 64'(tbl[i].exp_level));
        end
        @(negedge lrck);
        #1;
        rd  = frames.size();
        uf0 = uf_cnt;
        repeat (4) @(negedge clk);
        check("tbl_pop_level", 64'(fifo_level), 64'd2);
        for (int i = 0; i < 3; i++) check_pair("tbl", tbl[i].l, tbl[i].r);
        check("tbl_no_underflow", 64'(uf_cnt - uf0), 64'd0);

        // Backpressure: fill, hold off a 9th pair, release on the pop
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) push(bp[i], ~bp[i]);
        check("bp_full_level", 64'(fifo_level), 64'd8);
        check("bp_full_ready", 64'(sif.sample_ready), 64'd0);
        sif.sample_left  = bp[8];
        sif.sample_right = ~bp[8];
        sif.sample_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_held_level", 64'(fifo_level), 64'd8);
        @(negedge lrck);
        #1;
        rd = frames.size();
        @(negedge clk);
        @(negedge clk);
        check("bp_pre_pop_ready", 64'(sif.sample_ready), 64'd0);
        check("bp_pre_pop_level", 64'(fifo_level), 64'd8);
        @(negedge clk);
        check("bp_post_pop_ready", 64'(sif.sample_ready), 64'd1);
        check("bp_post_pop_level", 64'(fifo_level), 64'd7);
        @(negedge clk);
        check("bp_refill_level", 64'(fifo_level), 64'd8);
        sif.sample_valid = 1'b0;
        for (int i = 0; i < 9; i++) check_pair("bp", bp[i], ~bp[i]);

        // Push in the very cycle of the LRCK-fall pop
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) push(sp[i], ~sp[i]);
        check("sim_level3", 64'(fifo_level), 64'd3);
        @(negedge lrck);
        #1;
        rd = frames.size();
        @(negedge clk);
        @(negedge clk);
        check("sim_pre_level", 64'(fifo_level), 64'd3);
        sif.sample_left  = sp[3];
        sif.sample_right = ~sp[3];
        sif.sample_valid = 1'b1;
        @(negedge clk);
        sif.sample_valid = 1'b0;
        check("sim_level", 64'(fifo_level), 64'd3);
        for (int i = 0; i < 4; i++) check_pair("sim", sp[i], ~sp[i]);

        // Reset in the middle of a left word
        repeat (20) @(negedge clk);
        push(16'hFFFF, 16'hFFFF);
        push(16'hFFFF, 16'hFFFF);
        @(negedge lrck);
        repeat (8) @(posedge bclk);
        @(negedge clk);
        @(negedge clk);
        check("mid_dacdat_one", 64'(dacdat), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dacdat", 64'(dacdat), 64'd0);
        check("mid_rst_level", 64'(fifo_level), 64'd0);
        check("mid_rst_ready", 64'(sif.sample_ready), 64'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        ones0 = ones_cnt;
        push(16'hC3A5, 16'h5AA5);
        @(negedge lrck);
        check("post_rst_quiet", 64'(ones_cnt - ones0), 64'd0);
        #1;
        rd = frames.size();
        check_pair("post_rst", 16'hC3A5, 16'h5AA5);

        // Short frames: LRCK every 10 BCLK, MSB still in slot 2
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) push(sh[i], ~sh[i]);
        @(negedge lrck);
        half_len = 10;
        #1;
        rd = frames.size();
        for (int i = 0; i < 2; i++) begin
            get_rec(f);
            check("short_l_slot", 64'(f.lr), 64'd0);
            check("short_l_word", 64'(slot_word(f.cap, 9)), 64'(sh[i] & 16'hFF80));
            get_rec(f);
            check("short_r_slot", 64'(f.lr), 64'd1);
            check("short_r_word", 64'(slot_word(f.cap, 9)), 64'(~sh[i] & 16'hFF80));
        end
        half_len = 32;
        get_rec(f);
        check("short_recover_slot", 64'(f.lr), 64'd0);
        check("short_recover_word", 64'(slot_word(f.cap, DW)), 64'(sh[2]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
